// File: rtl/alu_exec_ctrl_if.sv
// Request/response bundle for the ALU execute controller: operation request in,
// registered result, status and decoded control code out.
interface alu_exec_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
);
   logic              valid_i;
   logic [2:0]        ALUOp_i;
   logic [5:0]        funct_i;
   logic [DATA_W-1:0] src1_i;
   logic [DATA_W-1:0] src2_i;
   logic              flush_i;
   logic              ready_o;
   logic              valid_o;
   logic [DATA_W-1:0] result_o;
   logic              zero_o;
   logic [CTRL_W-1:0] ALUCtrl_o;
   logic              illegal_o;

   modport master (
      output valid_i, ALUOp_i, funct_i, src1_i, src2_i, flush_i,
      input  ready_o, valid_o, result_o, zero_o, ALUCtrl_o, illegal_o
   );

   modport slave (
      input  valid_i, ALUOp_i, funct_i, src1_i, src2_i, flush_i,
      output ready_o, valid_o, result_o, zero_o, ALUCtrl_o, illegal_o
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// ALU execute controller: decodes ALUOp/funct, runs single-cycle ops directly and
// a DATA_W-step shift-add multiply in a MUL state. DATA_W is meant for 8..64.
module alu_exec_ctrl #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input logic           clk_i,
   input logic           rst_i,
   alu_exec_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W) + 1;

   localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'd0);
   localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'd1);
   localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'd2);
   localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'd6);
   localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(4'd7);
   localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(4'd11);
   localparam logic [CTRL_W-1:0] OP_BNE = CTRL_W'(4'd12);
   localparam logic [CTRL_W-1:0] OP_BGE = CTRL_W'(4'd13);
   localparam logic [CTRL_W-1:0] OP_BGT = CTRL_W'(4'd14);
   localparam logic [CTRL_W-1:0] OP_ILL = CTRL_W'(4'd15);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Returns {illegal, code}; funct is only consulted for the R-type class.
   function automatic logic [CTRL_W:0] decode_op(input logic [2:0] alu_op,
                                                  input logic [5:0] funct);
      logic [CTRL_W:0] dec;
      case (alu_op)
         3'b011:  dec = {1'b0, OP_ADD};
         3'b001:  dec = {1'b0, OP_SUB};
         3'b100:  dec = {1'b0, OP_SLT};
         3'b101:  dec = {1'b0, OP_BNE};
         3'b110:  dec = {1'b0, OP_BGE};
         3'b111:  dec = {1'b0, OP_BGT};
         3'b010:  dec = {1'b1, OP_ILL};
         3'b000: begin
            case (funct)
               6'd32:   dec = {1'b0, OP_ADD};
               6'd34:   dec = {1'b0, OP_SUB};
               6'd36:   dec = {1'b0, OP_AND};
               6'd37:   dec = {1'b0, OP_OR};
               6'd42:   dec = {1'b0, OP_SLT};
               6'd24:   dec = {1'b0, OP_MUL};
               default: dec = {1'b1, OP_ILL};
            endcase
         end
         default: dec = {1'b1, OP_ILL};
      endcase
      return dec;
   endfunction

   // Single-cycle result; comparisons yield 0/1 in the low bit.
   function automatic logic [DATA_W-1:0] alu_calc(input logic [CTRL_W-1:0] code,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] res;
      case (code)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  res = a + b;
         OP_SUB:  res = a - b;
         OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_BNE:  res = {{(DATA_W-1){1'b0}}, (a != b)};
         OP_BGE:  res = {{(DATA_W-1){1'b0}}, ($signed(a) >= $signed(b))};
         OP_BGT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) > $signed(b))};
         default: res = {DATA_W{1'b0}};
      endcase
      return res;
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [DATA_W-1:0]   a_r;
   logic [DATA_W-1:0]   b_r;
   logic [DATA_W-1:0]   acc_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [DATA_W-1:0]   result_r;
   logic                zero_r;
   logic [CTRL_W-1:0]   ctrl_r;
   logic                valid_r;
   logic                illegal_r;

   logic                ready_s;
   logic                accept_s;
   logic [CTRL_W:0]     dec_s;
   logic [CTRL_W-1:0]   dec_code_s;
   logic                dec_illegal_s;
   logic [DATA_W-1:0]   alu_res_s;
   logic [DATA_W-1:0]   acc_nxt_s;
   logic                mul_last_s;

   assign ready_s       = (state_r == ST_IDLE);
   assign accept_s      = bus.valid_i & ready_s & ~bus.flush_i;
   assign dec_s         = decode_op(bus.ALUOp_i, bus.funct_i);
   assign dec_code_s    = dec_s[CTRL_W-1:0];
   assign dec_illegal_s = dec_s[CTRL_W];
   assign alu_res_s     = alu_calc(dec_code_s, bus.src1_i, bus.src2_i);
   // Low DATA_W bits of the product are the same for signed and unsigned operands.
   assign acc_nxt_s     = b_r[0] ? (acc_r + a_r) : acc_r;
   assign mul_last_s    = (cnt_r == CNT_W'(DATA_W - 1));

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; flush aborts a multiply even on its final step.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && (dec_code_s == OP_MUL)) begin
               state_nxt_s = ST_MUL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (bus.flush_i || mul_last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_MUL;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs; valid/illegal are single-cycle pulses.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         a_r       <= {DATA_W{1'b0}};
         b_r       <= {DATA_W{1'b0}};
         acc_r     <= {DATA_W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         result_r  <= {DATA_W{1'b0}};
         zero_r    <= 1'b1;
         ctrl_r    <= {CTRL_W{1'b0}};
         valid_r   <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         valid_r   <= 1'b0;
         illegal_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  ctrl_r <= dec_code_s;
                  if (dec_code_s == OP_MUL) begin
                     a_r   <= bus.src1_i;
                     b_r   <= bus.src2_i;
                     acc_r <= {DATA_W{1'b0}};
                     cnt_r <= {CNT_W{1'b0}};
                  end else begin
                     result_r  <= alu_res_s;
                     zero_r    <= (alu_res_s == {DATA_W{1'b0}});
                     valid_r   <= 1'b1;
                     illegal_r <= dec_illegal_s;
                  end
               end
            end
            ST_MUL: begin
               if (!bus.flush_i) begin
                  acc_r <= acc_nxt_s;
                  a_r   <= {a_r[DATA_W-2:0], 1'b0};
                  b_r   <= {1'b0, b_r[DATA_W-1:1]};
                  cnt_r <= cnt_r + CNT_W'(1'b1);
                  if (mul_last_s) begin
                     result_r <= acc_nxt_s;
                     zero_r   <= (acc_nxt_s == {DATA_W{1'b0}});
                     valid_r  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready_o   = ready_s;
   assign bus.valid_o   = valid_r;
   assign bus.result_o  = result_r;
   assign bus.zero_o    = zero_r;
   assign bus.ALUCtrl_o = ctrl_r;
   assign bus.illegal_o = illegal_r;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: table of single-cycle vectors plus
// hand-written multiply, flush and reset sequences.
module tb_alu_exec_ctrl;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   passed = 0;
   int   total  = 0;

   alu_exec_ctrl_if #(.DATA_W(32), .CTRL_W(4)) bus ();

   alu_exec_ctrl #(.DATA_W(32), .CTRL_W(4)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic [3:0]  exp_ctrl;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      bus.valid_i = v;
      bus.ALUOp_i = op;
      bus.funct_i = fn;
      bus.src1_i  = a;
      bus.src2_i  = b;
   endtask

   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int lat;
      int busy_err;
      lat = 0;
      busy_err = 0;
      @(negedge clk_i);
      drive(1'b1, 3'b000, 6'd24, a, b);
      @(posedge clk_i); #1;
      check("mul_accept_ready", bus.ready_o, 0);
      check("mul_accept_ctrl", bus.ALUCtrl_o, 11);
      // Keep an ADD request pending while busy; it must be ignored.
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge clk_i);
         bus.funct_i = 6'd32;
         if (n == 32) bus.valid_i = 1'b0;
         @(posedge clk_i); #1;
         if (bus.valid_o) lat = n;
         else if (bus.ready_o) busy_err++;
      end
      check("mul_latency", lat, 32);
      check("mul_busy", busy_err, 0);
      check("mul_result", bus.result_o, exp);
      check("mul_zero", bus.zero_o, (exp == 32'd0));
      check("mul_ctrl", bus.ALUCtrl_o, 11);
      check("mul_illegal", bus.illegal_o, 0);
      @(posedge clk_i); #1;
      check("mul_pulse_end", bus.valid_o, 0);
      check("mul_hold", bus.result_o, exp);
   endtask

   initial begin
      vecs[0]  = '{3'b000, 6'd32, 32'd5, 32'd7, 32'd12, 1'b0, 4'd2, 1'b0};
      vecs[1]  = '{3'b000, 6'd34, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 4'd6, 1'b0};
      vecs[2]  = '{3'b000, 6'd36, 32'd5, 32'd7, 32'd5, 1'b0, 4'd0, 1'b0};
      vecs[3]  = '{3'b000, 6'd37, 32'd5, 32'd7, 32'd7, 1'b0, 4'd1, 1'b0};
      vecs[4]  = '{3'b000, 6'd42, 32'd5, 32'd7, 32'd1, 1'b0, 4'd7, 1'b0};
      vecs[5]  = '{3'b001, 6'd0, 32'd9, 32'd9, 32'd0, 1'b1, 4'd6, 1'b0};
      vecs[6]  = '{3'b110, 6'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 4'd13, 1'b0};
      vecs[7]  = '{3'b111, 6'd0, 32'd3, 32'hFFFFFFFE, 32'd1, 1'b0, 4'd14, 1'b0};
      vecs[8]  = '{3'b000, 6'd63, 32'd5, 32'd7, 32'd0, 1'b1, 4'd15, 1'b1};
      vecs[9]  = '{3'b010, 6'd32, 32'd5, 32'd7, 32'd0, 1'b1, 4'd15, 1'b1};
      vecs[10] = '{3'b011, 6'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 4'd2, 1'b0};
      vecs[11] = '{3'b100, 6'd0, 32'hFFFFFFFB, 32'd3, 32'd1, 1'b0, 4'd7, 1'b0};
      vecs[12] = '{3'b101, 6'd0, 32'd4, 32'd4, 32'd0, 1'b1, 4'd12, 1'b0};
      vecs[13] = '{3'b101, 6'd0, 32'd4, 32'd5, 32'd1, 1'b0, 4'd12, 1'b0};
      vecs[14] = '{3'b110, 6'd0, 32'd4, 32'd4, 32'd1, 1'b0, 4'd13, 1'b0};
      vecs[15] = '{3'b000, 6'd36, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 4'd0, 1'b0};

      drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0);
      bus.flush_i = 1'b0;
      #12;
      check("rst_ready", bus.ready_o, 1);
      check("rst_valid", bus.valid_o, 0);
      check("rst_result", bus.result_o, 0);
      check("rst_zero", bus.zero_o, 1);
      check("rst_ctrl", bus.ALUCtrl_o, 0);
      check("rst_illegal", bus.illegal_o, 0);

      // Back-to-back single-cycle ops starting on the first edge out of reset.
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b);
         @(posedge clk_i); #1;
         check($sformatf("v%0d_valid", i), bus.valid_o, 1);
         check($sformatf("v%0d_result", i), bus.result_o, vecs[i].exp_res);
         check($sformatf("v%0d_zero", i), bus.zero_o, vecs[i].exp_zero);
         check($sformatf("v%0d_ctrl", i), bus.ALUCtrl_o, vecs[i].exp_ctrl);
         check($sformatf("v%0d_illegal", i), bus.illegal_o, vecs[i].exp_ill);
         @(negedge clk_i);
      end
      bus.valid_i = 1'b0;
      @(posedge clk_i); #1;
      check("idle_no_valid", bus.valid_o, 0);

      do_mul(32'd6, 32'hFFFFFFFD, 32'hFFFFFFEE);
      do_mul(32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      do_mul(32'd0, 32'd12345, 32'd0);
      do_mul(32'hFFFFFFF9, 32'hFFFFFFF9, 32'd49);

      // Flush during the 10th multiply cycle.
      begin
         int seen;
         seen = 0;
         @(negedge clk_i);
         drive(1'b1, 3'b000, 6'd24, 32'd3, 32'd3);
         @(posedge clk_i); #1;
         for (int n = 1; n <= 10; n++) begin
            @(negedge clk_i);
            bus.valid_i = 1'b0;
            if (n == 10) bus.flush_i = 1'b1;
            @(posedge clk_i); #1;
            if (bus.valid_o) seen++;
         end
         check("flush_no_valid", seen, 0);
         check("flush_ready", bus.ready_o, 1);
         check("flush_result", bus.result_o, 49);
         @(negedge clk_i);
         bus.flush_i = 1'b0;
         drive(1'b1, 3'b000, 6'd32, 32'd2, 32'd3);
         @(posedge clk_i); #1;
         check("post_flush_valid", bus.valid_o, 1);
         check("post_flush_result", bus.result_o, 5);
      end

      // Flush with a request in IDLE drops it.
      @(negedge clk_i);
      drive(1'b1, 3'b001, 6'd0, 32'd100, 32'd1);
      bus.flush_i = 1'b1;
      @(posedge clk_i); #1;
      check("drop_valid", bus.valid_o, 0);
      check("drop_result", bus.result_o, 5);
      check("drop_ctrl", bus.ALUCtrl_o, 2);

      // Flush after acceptance leaves the scheduled pulse alone.
      @(negedge clk_i);
      bus.flush_i = 1'b0;
      drive(1'b1, 3'b011, 6'd0, 32'd1, 32'd1);
      @(posedge clk_i); #1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b1;
      #1;
      check("flush_late_valid", bus.valid_o, 1);
      check("flush_late_result", bus.result_o, 2);
      @(negedge clk_i);
      bus.flush_i = 1'b0;

      // Asynchronous reset in the 5th multiply cycle.
      begin
         int seen;
         seen = 0;
         drive(1'b1, 3'b000, 6'd24, 32'd7, 32'd7);
         @(posedge clk_i); #1;
         bus.valid_i = 1'b0;
         for (int n = 1; n <= 4; n++) @(posedge clk_i);
         #2;
         rst_i = 1'b0;
         #1;
         check("arst_ready", bus.ready_o, 1);
         check("arst_valid", bus.valid_o, 0);
         check("arst_result", bus.result_o, 0);
         check("arst_zero", bus.zero_o, 1);
         check("arst_ctrl", bus.ALUCtrl_o, 0);
         check("arst_illegal", bus.illegal_o, 0);
         @(negedge clk_i);
         @(negedge clk_i);
         rst_i = 1'b1;
         for (int n = 0; n < 40; n++) begin
            @(posedge clk_i); #1;
            if (bus.valid_o) seen++;
         end
         check("arst_no_valid", seen, 0);
         check("arst_ready_after", bus.ready_o, 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
